mem_cmd_bridge: RTL and testbench

MEM_CMD_BRIDGE -- requirements
Module: mem_cmd_bridge

---
 rtl/mem_cmd_bridge.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_cmd_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_bridge.sv
// Bridges a simple processor command port (read, write, interrupt) onto an
// AXI4-Lite master, one transaction per command, with a busy-cycle watchdog.
module mem_cmd_bridge #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  command,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        ready,
    output logic [31:0] data_rdata,
    output logic [1:0]  error,
    output logic        interrupt_req,
    input  logic        interrupt_ack,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LP_CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ADDR  = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_WR       = 3'd3,
        ST_WR_RESP  = 3'd4,
        ST_INT_WAIT = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ready;
    logic [1:0]    r_error;
    logic [31:0]   r_rdata;
    logic          r_int_req;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic          r_arvalid;
    logic          r_rready;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_bready;
    logic [CW-1:0] r_cnt;

    logic          w_ready_nxt;
    logic [1:0]    w_error_nxt;
    logic [31:0]   w_rdata_nxt;
    logic          w_int_req_nxt;
    logic          w_arvalid_nxt;
    logic          w_rready_nxt;
    logic          w_awvalid_nxt;
    logic          w_wvalid_nxt;
    logic          w_bready_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_accept;
    logic          w_busy;
    logic          w_aw_pend;
    logic          w_w_pend;
    logic          w_unused_addr;

    // Low address bits are discarded: the bus address is always word-aligned.
    assign w_unused_addr = ^data_addr[1:0];

    assign w_busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_aw_pend = r_awvalid & ~m_awready;
    assign w_w_pend  = r_wvalid & ~m_wready;

    // Next-state, next-output and watchdog decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_error_nxt   = r_error;
        w_rdata_nxt   = r_rdata;
        w_int_req_nxt = 1'b0;
        w_arvalid_nxt = 1'b0;
        w_rready_nxt  = 1'b0;
        w_awvalid_nxt = 1'b0;
        w_wvalid_nxt  = 1'b0;
        w_bready_nxt  = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_accept      = 1'b0;
        w_ready_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = {CW{1'b0}};
                if (command != 2'b00) begin
                    w_accept    = 1'b1;
                    w_error_nxt = 2'b00;
                    case (command)
                        2'b01: begin
                            w_state_nxt   = ST_RD_ADDR;
                            w_arvalid_nxt = 1'b1;
                        end
                        2'b10: begin
                            // An all-zero strobe write has nothing to move on the bus.
                            if (data_wstrb == 4'b0000) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_state_nxt   = ST_WR;
                                w_awvalid_nxt = 1'b1;
                                w_wvalid_nxt  = 1'b1;
                            end
                        end
                        2'b11: begin
                            w_state_nxt   = ST_INT_WAIT;
                            w_int_req_nxt = 1'b1;
                        end
                        default: w_state_nxt = ST_IDLE;
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (m_arready) begin
                    w_state_nxt  = ST_RD_DATA;
                    w_rready_nxt = 1'b1;
                end else begin
                    w_arvalid_nxt = 1'b1;
                end
            end
            ST_RD_DATA: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (m_rvalid) begin
                    w_state_nxt = ST_DONE;
                    w_rdata_nxt = m_rdata;
                    w_error_nxt = m_rresp;
                end else begin
                    w_rready_nxt = 1'b1;
                end
            end
            ST_WR: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (!w_aw_pend && !w_w_pend) begin
                    w_state_nxt  = ST_WR_RESP;
                    w_bready_nxt = 1'b1;
                end else begin
                    w_awvalid_nxt = w_aw_pend;
                    w_wvalid_nxt  = w_w_pend;
                end
            end
            ST_WR_RESP: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (m_bvalid) begin
                    w_state_nxt = ST_DONE;
                    w_error_nxt = m_bresp;
                end else begin
                    w_bready_nxt = 1'b1;
                end
            end
            ST_INT_WAIT: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (interrupt_ack) begin
                    w_state_nxt = ST_DONE;
                    w_error_nxt = 2'b00;
                end else begin
                    w_int_req_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                if (command == 2'b00) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A handshake landing on the last allowed cycle still completes normally.
        if (w_busy && (r_cnt == LP_CNT_LAST) && (w_state_nxt != ST_DONE)) begin
            w_state_nxt   = ST_DONE;
            w_error_nxt   = 2'b11;
            w_int_req_nxt = 1'b0;
            w_arvalid_nxt = 1'b0;
            w_rready_nxt  = 1'b0;
            w_awvalid_nxt = 1'b0;
            w_wvalid_nxt  = 1'b0;
            w_bready_nxt  = 1'b0;
            w_ready_nxt   = 1'b1;
        end else begin
            w_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE);
        end
    end

    // State and registered outputs; command fields captured on acceptance.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b0;
            r_error   <= 2'b00;
            r_rdata   <= 32'h0000_0000;
            r_int_req <= 1'b0;
            r_addr    <= 32'h0000_0000;
            r_wdata   <= 32'h0000_0000;
            r_wstrb   <= 4'b0000;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_cnt     <= {CW{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_ready   <= w_ready_nxt;
            r_error   <= w_error_nxt;
            r_rdata   <= w_rdata_nxt;
            r_int_req <= w_int_req_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_accept) begin
                r_addr  <= {data_addr[31:2], 2'b00};
                r_wdata <= data_wdata;
                r_wstrb <= data_wstrb;
            end
        end
    end

    assign ready         = r_ready;
    assign error         = r_error;
    assign data_rdata    = r_rdata;
    assign interrupt_req = r_int_req;
    assign m_awaddr      = r_addr;
    assign m_araddr      = r_addr;
    assign m_awvalid     = r_awvalid;
    assign m_wdata       = r_wdata;
    assign m_wstrb       = r_wstrb;
    assign m_wvalid      = r_wvalid;
    assign m_bready      = r_bready;
    assign m_arvalid     = r_arvalid;
    assign m_rready      = r_rready;

endmodule

// File: tb/tb_mem_cmd_bridge.sv
// Randomized bench for mem_cmd_bridge: a latency-configurable AXI4-Lite slave
// plus a transaction-level expectation model for result, status and timing.
module tb_mem_cmd_bridge;
    localparam int TO = 16;

    logic        clk;
    logic        resetn;
    logic [1:0]  command;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        ready;
    logic [31:0] data_rdata;
    logic [1:0]  error;
    logic        interrupt_req;
    logic        interrupt_ack;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    mem_cmd_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .command(command), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb), .ready(ready),
        .data_rdata(data_rdata), .error(error), .interrupt_req(interrupt_req),
        .interrupt_ack(interrupt_ack),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration (wait cycles before ready/valid) and observations.
    int ar_lat, r_lat, aw_lat, w_lat, b_lat;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;
    int ar_wait, r_wait, aw_wait, w_wait, b_wait;
    bit r_pend, b_pend, b_started;
    int ar_hs, r_hs, aw_hs, w_hs, b_hs, aww_cycles, int_cycles;
    logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
    logic [3:0]  seen_wstrb;
    logic [31:0] model_rdata;

    task automatic slave_reset();
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        r_pend = 0; b_pend = 0; b_started = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        aww_cycles = 0; int_cycles = 0;
        m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
        seen_araddr = 32'h0; seen_awaddr = 32'h0; seen_wdata = 32'h0; seen_wstrb = 4'h0;
    endtask

    // Called on each falling edge: decide this cycle's slave signals, note
    // which handshakes will complete at the coming rising edge.
    task automatic slave_step();
        if (r_pend && r_wait >= r_lat) begin
            m_rvalid = 1'b1; m_rdata = s_rdata; m_rresp = s_rresp;
        end else begin
            m_rvalid = 1'b0;
            if (r_pend) r_wait++;
        end
        if (m_rvalid && m_rready) begin r_hs++; r_pend = 0; end
        if (b_pend && b_wait >= b_lat) begin
            m_bvalid = 1'b1; m_bresp = s_bresp;
        end else begin
            m_bvalid = 1'b0;
            if (b_pend) b_wait++;
        end
        if (m_bvalid && m_bready) begin b_hs++; b_pend = 0; end
        m_arready = 1'b0;
        if (m_arvalid) begin
            if (ar_wait >= ar_lat) m_arready = 1'b1; else ar_wait++;
        end
        if (m_arvalid && m_arready) begin
            ar_hs++; seen_araddr = m_araddr; r_pend = 1; r_wait = 0;
        end
        m_awready = 1'b0;
        if (m_awvalid) begin
            if (aw_wait >= aw_lat) m_awready = 1'b1; else aw_wait++;
        end
        if (m_awvalid && m_awready) begin aw_hs++; seen_awaddr = m_awaddr; end
        m_wready = 1'b0;
        if (m_wvalid) begin
            if (w_wait >= w_lat) m_wready = 1'b1; else w_wait++;
        end
        if (m_wvalid && m_wready) begin w_hs++; seen_wdata = m_wdata; seen_wstrb = m_wstrb; end
        if (aw_hs > 0 && w_hs > 0 && !b_started) begin
            b_started = 1; b_pend = 1; b_wait = 0;
        end
        if (m_awvalid || m_wvalid) aww_cycles++;
        if (interrupt_req) int_cycles++;
    endtask

    task automatic tick();
        @(negedge clk);
        slave_step();
    endtask

    // Issue one command from IDLE, hold it through DONE, then release it.
    task automatic run_txn(input string tag, input logic [1:0] cmd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int ack_dly, input int hold);
        int n, t, exp_n;
        bit done;
        logic [1:0] exp_err;
        logic [39:0] exp_hs;
        exp_hs = 40'h0;
        exp_err = 2'b00;
        if (cmd == 2'b01) begin
            t = ar_lat + r_lat + 3;
            if (t - 1 > TO) begin
                exp_n = TO + 1; exp_err = 2'b11;
            end else begin
                exp_n = t; exp_err = s_rresp; model_rdata = s_rdata;
                exp_hs = {8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
            end
        end else if (cmd == 2'b10 && strb != 4'b0000) begin
            t = ((aw_lat > w_lat) ? aw_lat : w_lat) + b_lat + 3;
            if (t - 1 > TO) begin
                exp_n = TO + 1; exp_err = 2'b11;
            end else begin
                exp_n = t; exp_err = s_bresp;
                exp_hs = {8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
            end
        end else if (cmd == 2'b10) begin
            exp_n = 1;
        end else begin
            exp_n = ack_dly + 1;
        end
        slave_reset();
        check_eq({tag, ".idle_ready"}, {63'd0, ready}, 64'd1);
        command = cmd; data_addr = addr; data_wdata = wdata; data_wstrb = strb;
        n = 0; done = 0;
        while (!done && n < 60) begin
            tick();
            n++;
            if (ready) done = 1;
            else if (cmd == 2'b11 && n == ack_dly) interrupt_ack = 1'b1;
        end
        interrupt_ack = 1'b0;
        check_eq({tag, ".latency"}, 64'(n), 64'(exp_n));
        check_eq({tag, ".error"}, {62'd0, error}, {62'd0, exp_err});
        check_eq({tag, ".rdata"}, {32'd0, data_rdata}, {32'd0, model_rdata});
        if (exp_err != 2'b11) begin
            check_eq({tag, ".hs"}, {24'd0, 8'(ar_hs), 8'(r_hs), 8'(aw_hs), 8'(w_hs), 8'(b_hs)},
                     {24'd0, exp_hs});
        end else begin
            check_eq({tag, ".to_quiet"},
                     {59'd0, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, 64'd0);
        end
        if (cmd == 2'b01 && exp_err != 2'b11)
            check_eq({tag, ".araddr"}, {32'd0, seen_araddr}, {32'd0, addr[31:2], 2'b00});
        if (exp_hs[15:8] == 8'd1)
            check_eq({tag, ".wbeat"}, {seen_awaddr, seen_wdata[27:0], seen_wstrb},
                     {addr[31:2], 2'b00, wdata[27:0], strb});
        if (cmd == 2'b10 && strb == 4'b0000)
            check_eq({tag, ".no_bus"}, 64'(aww_cycles), 64'd0);
        for (int h = 0; h < hold; h++) tick();
        check_eq({tag, ".done_hold"},
                 {8'd0, ready, interrupt_req, 6'd0, 8'(ar_hs), 8'(aw_hs), 8'(int_cycles), 24'd0},
                 {8'd0, 1'b1, 1'b0, 6'd0, exp_hs[39:32], exp_hs[23:16],
                  8'(cmd == 2'b11 ? ack_dly : 0), 24'd0});
        command = 2'b00;
        tick();
        check_eq({tag, ".back_idle"}, {63'd0, ready}, 64'd1);
    endtask

    initial begin
        int bnd;
        resetn = 1'b0; command = 2'b00; data_addr = 32'h0; data_wdata = 32'h0;
        data_wstrb = 4'h0; interrupt_ack = 1'b0;
        m_rdata = 32'h0; m_rresp = 2'b00; m_bresp = 2'b00;
        ar_lat = 0; r_lat = 0; aw_lat = 0; w_lat = 0; b_lat = 0;
        s_rdata = 32'h0; s_rresp = 2'b00; s_bresp = 2'b00;
        model_rdata = 32'h0;
        slave_reset();
        repeat (3) tick();
        check_eq("reset.state",
                 {ready, interrupt_req, error, m_arvalid, m_rready, m_awvalid, m_wvalid,
                  m_bready, data_rdata},
                 {9'd0, 32'd0});
        resetn = 1'b1;
        tick();
        check_eq("reset.first_ready", {63'd0, ready}, 64'd1);

        s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
        run_txn("rd_zero_wait", 2'b01, 32'h0000_1003, 32'h0, 4'h0, 0, 1);

        aw_lat = 2; w_lat = 0; b_lat = 0; s_bresp = 2'b10;
        run_txn("wr_aw_late", 2'b10, 32'h0000_2000, 32'h1234_5678, 4'b0101, 0, 0);

        run_txn("wr_strb0", 2'b10, 32'h0000_3000, 32'hCAFE_F00D, 4'b0000, 0, 2);

        ar_lat = 1000; r_lat = 0;
        run_txn("rd_timeout", 2'b01, 32'h0000_4004, 32'h0, 4'h0, 0, 0);
        ar_lat = 0;

        run_txn("int_ack5", 2'b11, 32'h0, 32'h0, 4'h0, 5, 3);

        for (int i = 0; i < 30; i++) begin
            logic [1:0] c;
            c = 2'($urandom_range(1, 3));
            ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
            b_lat = $urandom_range(0, 3);
            s_rdata = $urandom; s_rresp = 2'($urandom_range(0, 3));
            s_bresp = 2'($urandom_range(0, 3));
            run_txn($sformatf("rand%0d", i), c, $urandom, $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(1, 6), $urandom_range(0, 2));
        end

        // Reset while the write response is outstanding.
        slave_reset();
        aw_lat = 0; w_lat = 0; b_lat = 20; s_bresp = 2'b10;
        command = 2'b10; data_addr = 32'h0000_5000; data_wdata = 32'h5555_AAAA; data_wstrb = 4'hF;
        bnd = 0;
        do begin
            tick();
            bnd++;
        end while (!m_bready && bnd < 10);
        check_eq("rst.in_wr_resp", {63'd0, m_bready}, 64'd1);
        resetn = 1'b0; command = 2'b00;
        tick();
        slave_reset();
        model_rdata = 32'h0;
        check_eq("rst.aborted",
                 {ready, interrupt_req, error, m_arvalid, m_rready, m_awvalid, m_wvalid,
                  m_bready, data_rdata},
                 {9'd0, 32'd0});
        resetn = 1'b1;
        tick();
        check_eq("rst.release", {61'd0, ready, error}, {61'd0, 1'b1, 2'b00});
        b_lat = 0; s_rdata = 32'h0BAD_CAFE; s_rresp = 2'b01;
        run_txn("rd_after_rst", 2'b01, 32'h0000_6002, 32'h0, 4'h0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
